// File: rtl/llc_trace_cmd_queue.sv
// llc_trace_cmd_queue: filters illegal trace commands and queues legal ones in order for the LLC model,
// tagging each with a sequence number and tracking drop count and occupancy.
module llc_trace_cmd_queue #(
    parameter int DEPTH = 8,
    parameter int CNT_W = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [4:0]               in_command,
    input  logic [31:0]              in_address,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [4:0]               out_command,
    output logic [31:0]              out_address,
    output logic [CNT_W-1:0]         out_seq,
    output logic [$clog2(DEPTH):0]   occupancy,
    output logic [CNT_W-1:0]         drop_count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    logic [4:0]       cmd_mem  [DEPTH];
    logic [31:0]      addr_mem [DEPTH];
    logic [CNT_W-1:0] seq_mem  [DEPTH];

    logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]      occ_q, occ_d;
    logic [CNT_W-1:0] seq_q, seq_d, drop_q, drop_d;
    logic             legal, push, push_ok, pop;

    assign legal   = (in_command <= 5'd6) || (in_command == 5'd8) || (in_command == 5'd9);
    assign in_ready  = occ_q != FULL;
    assign out_valid = occ_q != '0;
    assign push    = in_valid && in_ready;
    assign push_ok = push && legal;
    assign pop     = out_valid && out_ready;

    assign out_command = cmd_mem[rd_ptr_q];
    assign out_address = addr_mem[rd_ptr_q];
    // Storage is never reset, so the sequence tag is forced to zero whenever the queue is empty.
    assign out_seq     = out_valid ? seq_mem[rd_ptr_q] : '0;
    assign occupancy   = occ_q;
    assign drop_count  = drop_q;

    always_comb begin
        wr_ptr_d = push_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
        occ_d    = (push_ok && !pop) ? occ_q + (AW+1)'(1) :
                   (pop && !push_ok) ? occ_q - (AW+1)'(1) : occ_q;
        seq_d    = push_ok ? seq_q + CNT_W'(1) : seq_q;
        drop_d   = (push && !legal && drop_q != '1) ? drop_q + CNT_W'(1) : drop_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
            seq_q    <= '0;
            drop_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
            seq_q    <= seq_d;
            drop_q   <= drop_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && push_ok) begin
            cmd_mem[wr_ptr_q]  <= in_command;
            addr_mem[wr_ptr_q] <= in_address;
            seq_mem[wr_ptr_q]  <= seq_q;
        end
    end
endmodule

// File: tb/tb_llc_trace_cmd_queue.sv
// tb_llc_trace_cmd_queue: randomized and directed checks of the trace command queue against a queue-based model.
module tb_llc_trace_cmd_queue;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [4:0]  in_command = '0;
    logic [31:0] in_address = '0;
    logic        in_ready, out_valid;
    logic [4:0]  out_command;
    logic [31:0] out_address;
    logic [15:0] out_seq, drop_count;
    logic [3:0]  occupancy;

    llc_trace_cmd_queue #(.DEPTH(8), .CNT_W(16)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_command(in_command), .in_address(in_address),
        .out_valid(out_valid), .out_ready(out_ready), .out_command(out_command),
        .out_address(out_address), .out_seq(out_seq), .occupancy(occupancy), .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0]  c;
        logic [31:0] a;
        logic [15:0] s;
    } ent_t;

    ent_t        mq[$];
    logic [15:0] m_seq = '0;
    logic [15:0] m_drop = '0;
    int          pass_cnt = 0;
    int          total_cnt = 0;

    function automatic bit is_legal(input logic [4:0] c);
        return (c <= 5'd6) || (c == 5'd8) || (c == 5'd9);
    endfunction

    function automatic logic [4:0] rand_legal();
        int r = $urandom_range(0, 8);
        return 5'(r < 7 ? r : r + 1);
    endfunction

    function automatic logic [4:0] rand_illegal();
        int r = $urandom_range(0, 22);
        return 5'(r == 0 ? 7 : r + 9);
    endfunction

    // One clock cycle: drive inputs, let the edge happen, then advance the model by the queue rules.
    task automatic tick(input bit v, input logic [4:0] c, input logic [31:0] a, input bit r);
        bit push, pop;
        in_valid = v; in_command = c; in_address = a; out_ready = r;
        pop  = (mq.size() != 0) && r;
        push = v && (mq.size() != 8);
        @(posedge clk); #1;
        if (pop) void'(mq.pop_front());
        if (push && is_legal(c)) begin
            mq.push_back('{c, a, m_seq});
            m_seq++;
        end else if (push && m_drop != 16'hFFFF) m_drop++;
    endtask

    task automatic do_reset(input bit v, input logic [4:0] c, input logic [31:0] a, input bit r);
        in_valid = v; in_command = c; in_address = a; out_ready = r;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        mq.delete(); m_seq = '0; m_drop = '0;
    endtask

    task automatic test_reset();
        do_reset(1'b1, 5'd3, 32'hDEAD_BEEF, 1'b1);
        total_cnt++; if (out_valid !== 1'b0) $display("FAIL rst_out_valid got=%0b exp=0", out_valid); else pass_cnt++;
        total_cnt++; if (in_ready !== 1'b1) $display("FAIL rst_in_ready got=%0b exp=1", in_ready); else pass_cnt++;
        total_cnt++; if (occupancy !== 4'd0) $display("FAIL rst_occupancy got=%0d exp=0", occupancy); else pass_cnt++;
        total_cnt++; if (drop_count !== 16'd0) $display("FAIL rst_drop got=%0d exp=0", drop_count); else pass_cnt++;
        total_cnt++; if (out_seq !== 16'd0) $display("FAIL rst_out_seq got=%0d exp=0", out_seq); else pass_cnt++;
    endtask

    task automatic test_pass_through();
        do_reset(1'b0, 5'd0, 32'h0, 1'b0);
        tick(1'b1, 5'd0, 32'h1000_019D, 1'b1);
        total_cnt++; if (out_valid !== 1'b1) $display("FAIL pt_valid got=%0b exp=1", out_valid); else pass_cnt++;
        total_cnt++; if (out_command !== 5'd0) $display("FAIL pt_cmd got=%0d exp=0", out_command); else pass_cnt++;
        total_cnt++; if (out_address !== 32'h1000_019D) $display("FAIL pt_addr got=%h exp=1000019d", out_address); else pass_cnt++;
        total_cnt++; if (out_seq !== 16'd0) $display("FAIL pt_seq got=%0d exp=0", out_seq); else pass_cnt++;
        tick(1'b0, 5'd0, 32'h0, 1'b1);
        total_cnt++; if (out_valid !== 1'b0) $display("FAIL pt_valid_after got=%0b exp=0", out_valid); else pass_cnt++;
        total_cnt++; if (occupancy !== 4'd0) $display("FAIL pt_occ_after got=%0d exp=0", occupancy); else pass_cnt++;
    endtask

    task automatic test_fill_stall();
        logic [4:0]  c9;
        logic [31:0] a9;
        ent_t        last;
        do_reset(1'b0, 5'd0, 32'h0, 1'b0);
        for (int k = 0; k < 8; k++) begin
            tick(1'b1, rand_legal(), $urandom, 1'b0);
            if (k == 6) begin
                total_cnt++; if (in_ready !== 1'b1) $display("FAIL fill_ready7 got=%0b exp=1", in_ready); else pass_cnt++;
            end
        end
        total_cnt++; if (in_ready !== 1'b0) $display("FAIL fill_ready8 got=%0b exp=0", in_ready); else pass_cnt++;
        total_cnt++; if (occupancy !== 4'd8) $display("FAIL fill_occ8 got=%0d exp=8", occupancy); else pass_cnt++;
        c9 = rand_legal(); a9 = $urandom;
        tick(1'b1, c9, a9, 1'b0);
        total_cnt++; if (occupancy !== 4'd8) $display("FAIL fill_stall_occ got=%0d exp=8", occupancy); else pass_cnt++;
        tick(1'b1, c9, a9, 1'b1);
        total_cnt++; if (occupancy !== 4'd7) $display("FAIL fill_pop_occ got=%0d exp=7", occupancy); else pass_cnt++;
        total_cnt++; if (in_ready !== 1'b1) $display("FAIL fill_ready_rise got=%0b exp=1", in_ready); else pass_cnt++;
        tick(1'b1, c9, a9, 1'b0);
        total_cnt++; if (occupancy !== 4'd8) $display("FAIL fill_ninth_occ got=%0d exp=8", occupancy); else pass_cnt++;
        last = '0;
        for (int k = 0; k < 8; k++) begin
            last = mq[0];
            total_cnt++;
            if ({out_valid, out_command, out_address, out_seq} !== {1'b1, mq[0].c, mq[0].a, mq[0].s})
                $display("FAIL fill_drain got=%0b/%0d/%h/%0d exp=1/%0d/%h/%0d", out_valid, out_command, out_address, out_seq, mq[0].c, mq[0].a, mq[0].s);
            else pass_cnt++;
            tick(1'b0, 5'd0, 32'h0, 1'b1);
        end
        total_cnt++; if ({last.c, last.a, last.s} !== {c9, a9, 16'd8}) $display("FAIL fill_ninth_entry got=%0d/%h/%0d exp=%0d/%h/8", last.c, last.a, last.s, c9, a9); else pass_cnt++;
    endtask

    task automatic test_illegal();
        do_reset(1'b0, 5'd0, 32'h0, 1'b0);
        tick(1'b1, 5'd7, 32'h11, 1'b1);
        tick(1'b1, 5'd12, 32'h22, 1'b1);
        tick(1'b1, 5'd31, 32'h33, 1'b1);
        total_cnt++; if (out_valid !== 1'b0) $display("FAIL ill_nothing_stored got=%0b exp=0", out_valid); else pass_cnt++;
        tick(1'b1, 5'd2, 32'h44, 1'b1);
        total_cnt++; if (drop_count !== 16'd3) $display("FAIL ill_drop got=%0d exp=3", drop_count); else pass_cnt++;
        total_cnt++; if ({out_valid, out_command, out_address, out_seq} !== {1'b1, 5'd2, 32'h44, 16'd0})
            $display("FAIL ill_head got=%0b/%0d/%h/%0d exp=1/2/44/0", out_valid, out_command, out_address, out_seq); else pass_cnt++;
        tick(1'b0, 5'd0, 32'h0, 1'b1);
        total_cnt++; if (occupancy !== 4'd0) $display("FAIL ill_only_one got=%0d exp=0", occupancy); else pass_cnt++;
    endtask

    task automatic test_wrap();
        logic [4:0]  cs[20];
        logic [31:0] as[20];
        int          i = 0, popped = 0, cyc = 0;
        bit          r, acc;
        do_reset(1'b0, 5'd0, 32'h0, 1'b0);
        for (int k = 0; k < 20; k++) begin cs[k] = rand_legal(); as[k] = $urandom; end
        while ((i < 20 || mq.size() != 0) && cyc < 200) begin
            r = (cyc % 2) == 0;
            if (mq.size() != 0 && r) begin
                total_cnt++;
                if ({out_valid, out_command, out_address, out_seq} !== {1'b1, cs[popped], as[popped], 16'(popped)})
                    $display("FAIL wrap_order%0d got=%0b/%0d/%h/%0d exp=1/%0d/%h/%0d", popped, out_valid, out_command, out_address, out_seq, cs[popped], as[popped], popped);
                else pass_cnt++;
                popped++;
            end
            acc = (i < 20) && (mq.size() != 8);
            tick(i < 20, i < 20 ? cs[i] : 5'd0, i < 20 ? as[i] : 32'h0, r);
            if (acc) i++;
            cyc++;
        end
        total_cnt++; if (popped !== 20) $display("FAIL wrap_count got=%0d exp=20", popped); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        ent_t second;
        do_reset(1'b0, 5'd0, 32'h0, 1'b0);
        for (int k = 0; k < 4; k++) tick(1'b1, rand_legal(), $urandom, 1'b0);
        second = mq[1];
        tick(1'b1, rand_legal(), $urandom, 1'b1);
        total_cnt++; if (occupancy !== 4'd4) $display("FAIL b2b_occ got=%0d exp=4", occupancy); else pass_cnt++;
        total_cnt++; if ({out_command, out_address, out_seq} !== {second.c, second.a, 16'd1})
            $display("FAIL b2b_head got=%0d/%h/%0d exp=%0d/%h/1", out_command, out_address, out_seq, second.c, second.a); else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        do_reset(1'b0, 5'd0, 32'h0, 1'b0);
        for (int k = 0; k < 7; k++) tick(1'b1, (k == 1 || k == 4) ? rand_illegal() : rand_legal(), $urandom, 1'b0);
        total_cnt++; if (occupancy !== 4'd5) $display("FAIL mid_pre_occ got=%0d exp=5", occupancy); else pass_cnt++;
        total_cnt++; if (drop_count !== 16'd2) $display("FAIL mid_pre_drop got=%0d exp=2", drop_count); else pass_cnt++;
        do_reset(1'b1, rand_legal(), $urandom, 1'b1);
        total_cnt++; if ({occupancy, drop_count, out_valid, in_ready} !== {4'd0, 16'd0, 1'b0, 1'b1})
            $display("FAIL mid_post got=occ%0d/drop%0d/v%0b/r%0b exp=occ0/drop0/v0/r1", occupancy, drop_count, out_valid, in_ready); else pass_cnt++;
        tick(1'b1, 5'd3, 32'hCAFE_0040, 1'b0);
        total_cnt++; if ({out_valid, out_command, out_seq} !== {1'b1, 5'd3, 16'd0})
            $display("FAIL mid_first_push got=%0b/%0d/%0d exp=1/3/0", out_valid, out_command, out_seq); else pass_cnt++;
    endtask

    task automatic test_random();
        bit r;
        do_reset(1'b0, 5'd0, 32'h0, 1'b0);
        for (int cyc = 0; cyc < 400; cyc++) begin
            total_cnt++; if (in_ready !== (mq.size() != 8)) $display("FAIL rnd_ready cyc%0d got=%0b exp=%0b", cyc, in_ready, mq.size() != 8); else pass_cnt++;
            total_cnt++; if (out_valid !== (mq.size() != 0)) $display("FAIL rnd_valid cyc%0d got=%0b exp=%0b", cyc, out_valid, mq.size() != 0); else pass_cnt++;
            total_cnt++; if (occupancy !== 4'(mq.size())) $display("FAIL rnd_occ cyc%0d got=%0d exp=%0d", cyc, occupancy, mq.size()); else pass_cnt++;
            total_cnt++; if (drop_count !== m_drop) $display("FAIL rnd_drop cyc%0d got=%0d exp=%0d", cyc, drop_count, m_drop); else pass_cnt++;
            if (mq.size() != 0) begin
                total_cnt++;
                if ({out_command, out_address, out_seq} !== {mq[0].c, mq[0].a, mq[0].s})
                    $display("FAIL rnd_head cyc%0d got=%0d/%h/%0d exp=%0d/%h/%0d", cyc, out_command, out_address, out_seq, mq[0].c, mq[0].a, mq[0].s);
                else pass_cnt++;
            end
            r = (cyc < 200) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            if (cyc == 300) do_reset(1'b1, rand_legal(), $urandom, 1'b1);
            else tick($urandom_range(0, 3) != 0, ($urandom_range(0, 3) == 0) ? rand_illegal() : rand_legal(), $urandom, r);
        end
    endtask

    initial begin
        test_reset();
        test_pass_through();
        test_fill_stall();
        test_illegal();
        test_wrap();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
